// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Architectural zero register: writes to it are dropped.
  localparam int unsigned REG_ZERO = 0;

  // NORMAL: pipeline has priority. FORCE: starved FIFO head takes the port.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_write_arbiter_result_fifo.sv
// Small synchronous FIFO for long-latency results, exposing per-entry
// valid/address so the owner can build a pending-register mask.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [ADDR_W-1:0]              i_push_addr,
  input  logic [DATA_W-1:0]              i_push_data,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [DEPTH-1:0]               o_entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_entry_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_data_q, mem_data_d;
  logic                          do_push, do_pop;

  assign o_full        = (count_q == CNT_W'(DEPTH));
  assign o_empty       = (count_q == '0);
  assign o_count       = count_q;
  assign o_head_addr   = mem_addr_q[rd_ptr_q];
  assign o_head_data   = mem_data_q[rd_ptr_q];
  assign o_entry_valid = valid_q;
  assign o_entry_addr  = mem_addr_q;

  // Next-state for pointers, count, storage and per-entry valid flags.
  always_comb begin
    do_push    = i_push && !o_full;
    do_pop     = i_pop && !o_empty;
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (do_push) begin
      mem_addr_d[wr_ptr_q] = i_push_addr;
      mem_data_d[wr_ptr_q] = i_push_data;
      valid_d[wr_ptr_q]    = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state register; reset discards all buffered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// buffered long-latency results, with a starvation-forced grant.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wb_regwrite,
  input  logic [ADDR_W-1:0]              i_wb_reg,
  input  logic [DATA_W-1:0]              i_wb_data,
  output logic                           o_wb_stall,
  input  logic                           i_lu_valid,
  input  logic [ADDR_W-1:0]              i_lu_reg,
  input  logic [DATA_W-1:0]              i_lu_data,
  output logic                           o_lu_ready,
  output logic                           o_rf_we,
  output logic [ADDR_W-1:0]              o_rf_addr,
  output logic [DATA_W-1:0]              o_rf_data,
  output logic [(2**ADDR_W)-1:0]         o_lu_pending,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e                        state_q, state_d;
  logic [WAIT_W-1:0]                 wait_q, wait_d;
  logic                              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]                 rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]                 rf_data_q, rf_data_d;

  logic                              wb_req, lu_push;
  logic                              grant_wb, grant_lu, wb_stall;
  logic [ADDR_W-1:0]                 head_addr;
  logic [DATA_W-1:0]                 head_data;
  logic                              fifo_full, fifo_empty;
  logic [FIFO_DEPTH-1:0]             entry_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] entry_addr;

  assign wb_req     = i_wb_regwrite && (i_wb_reg != ADDR_W'(REG_ZERO));
  // Zero-register results are acknowledged but never stored.
  assign lu_push    = i_lu_valid && !fifo_full && (i_lu_reg != ADDR_W'(REG_ZERO));
  assign o_lu_ready = !fifo_full;
  assign o_wb_stall = wb_stall;
  assign o_rf_we    = rf_we_q;
  assign o_rf_addr  = rf_addr_q;
  assign o_rf_data  = rf_data_q;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk           (i_clk),
    .rst           (i_rst),
    .i_push        (lu_push),
    .i_push_addr   (i_lu_reg),
    .i_push_data   (i_lu_data),
    .i_pop         (grant_lu),
    .o_head_addr   (head_addr),
    .o_head_data   (head_data),
    .o_count       (o_fifo_count),
    .o_full        (fifo_full),
    .o_empty       (fifo_empty),
    .o_entry_valid (entry_valid),
    .o_entry_addr  (entry_addr)
  );

  // Grant selection, stall, starvation counter and next RF write.
  always_comb begin
    grant_wb  = 1'b0;
    grant_lu  = 1'b0;
    wb_stall  = 1'b0;
    state_d   = ST_NORMAL;
    wait_d    = wait_q;
    if (state_q == ST_FORCE && !fifo_empty) begin
      grant_lu = 1'b1;
      wb_stall = wb_req;
    end else if (wb_req) begin
      grant_wb = 1'b1;
    end else if (!fifo_empty) begin
      grant_lu = 1'b1;
    end

    if (fifo_empty || grant_lu) begin
      wait_d = '0;
    end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
      wait_d  = '0;
      state_d = ST_FORCE;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end

    rf_we_d   = grant_wb || grant_lu;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant_lu) begin
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end else if (grant_wb) begin
      rf_addr_d = i_wb_reg;
      rf_data_d = i_wb_data;
    end
  end

  // One-hot OR of destinations still held in the FIFO.
  always_comb begin
    o_lu_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        o_lu_pending[entry_addr[i]] = 1'b1;
      end
    end
  end

  // Arbiter state and registered RF write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_NORMAL;
      wait_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench: directed vector table, async reset, and randomized
// traffic against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int MW = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          wb_regwrite;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          lu_valid;
  logic [AW-1:0] lu_reg;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [31:0]   lu_pending;
  logic [CW-1:0] fifo_count;

  wb_write_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_regwrite (wb_regwrite),
    .i_wb_reg      (wb_reg),
    .i_wb_data     (wb_data),
    .o_wb_stall    (wb_stall),
    .i_lu_valid    (lu_valid),
    .i_lu_reg      (lu_reg),
    .i_lu_data     (lu_data),
    .o_lu_ready    (lu_ready),
    .o_rf_we       (rf_we),
    .o_rf_addr     (rf_addr),
    .o_rf_data     (rf_data),
    .o_lu_pending  (lu_pending),
    .o_fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic          lv;
    logic [AW-1:0] lreg;
    logic [DW-1:0] ldata;
    logic          e_stall;
    logic          e_ready;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic [31:0]   e_pend;
  } vec_t;

  function automatic vec_t mk(input logic wr, input int wreg, input logic [DW-1:0] wdata,
                              input logic lv, input int lreg, input logic [DW-1:0] ldata,
                              input logic e_stall, input logic e_ready, input logic e_we,
                              input int e_addr, input logic [DW-1:0] e_data,
                              input int e_cnt, input logic [31:0] e_pend);
    vec_t v;
    v.wr = wr; v.wreg = AW'(wreg); v.wdata = wdata;
    v.lv = lv; v.lreg = AW'(lreg); v.ldata = ldata;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_we = e_we;
    v.e_addr = AW'(e_addr); v.e_data = e_data; v.e_cnt = CW'(e_cnt); v.e_pend = e_pend;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic [AW-1:0] wreg, input logic [DW-1:0] wdata,
                       input logic lv, input logic [AW-1:0] lreg, input logic [DW-1:0] ldata);
    wb_regwrite = wr; wb_reg = wreg; wb_data = wdata;
    lu_valid = lv; lu_reg = lreg; lu_data = ldata;
  endtask

  // Reference model: queue of buffered results plus the starvation rule.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  int            m_wait;
  bit            m_force;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_force = 0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[k]) p[mq[k].a] = 1'b1;
    return p;
  endfunction

  vec_t tbl[18];

  initial begin
    logic req, ne, full, fifo_g, wb_g, push, stall_prev;
    ent_t e;

    drive(0, '0, '0, 0, '0, '0);
    rst = 1'b1;
    #1;
    chk("reset_we", 32'(rf_we), 0);
    chk("reset_addr", 32'(rf_addr), 0);
    chk("reset_data", rf_data, 0);
    chk("reset_cnt", 32'(fifo_count), 0);
    chk("reset_pend", lu_pending, 0);
    chk("reset_stall", 32'(wb_stall), 0);
    chk("reset_ready", 32'(lu_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: each row is one cycle from the end of reset onwards.
    tbl[0]  = mk(1, 8, 32'h1234, 0, 0, 0,            0, 1, 1, 8, 32'h1234, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0,        1, 5, 32'hDEAD,     0, 1, 0, 8, 32'h1234, 1, 32'h20);
    tbl[2]  = mk(0, 0, 0,        0, 0, 0,            0, 1, 1, 5, 32'hDEAD, 0, 32'h0);
    tbl[3]  = mk(1, 0, 32'h55,   1, 0, 32'h77,       0, 1, 0, 5, 32'hDEAD, 0, 32'h0);
    tbl[4]  = mk(1, 3, 32'h33,   1, 10, 32'hA,       0, 1, 1, 3, 32'h33,   1, 32'h400);
    tbl[5]  = mk(1, 4, 32'h44,   1, 11, 32'hB,       0, 1, 1, 4, 32'h44,   2, 32'hC00);
    tbl[6]  = mk(1, 6, 32'h66,   1, 12, 32'hC,       0, 0, 1, 6, 32'h66,   2, 32'hC00);
    tbl[7]  = mk(0, 0, 0,        1, 12, 32'hC,       0, 0, 1, 10, 32'hA,   1, 32'h800);
    tbl[8]  = mk(0, 0, 0,        1, 13, 32'hD,       0, 1, 1, 11, 32'hB,   1, 32'h2000);
    tbl[9]  = mk(0, 0, 0,        0, 0, 0,            0, 1, 1, 13, 32'hD,   0, 32'h0);
    tbl[10] = mk(1, 7, 32'h70,   1, 9, 32'h99,       0, 1, 1, 7, 32'h70,   1, 32'h200);
    tbl[11] = mk(1, 7, 32'h71,   0, 0, 0,            0, 1, 1, 7, 32'h71,   1, 32'h200);
    tbl[12] = mk(1, 7, 32'h72,   0, 0, 0,            0, 1, 1, 7, 32'h72,   1, 32'h200);
    tbl[13] = mk(1, 7, 32'h73,   0, 0, 0,            0, 1, 1, 7, 32'h73,   1, 32'h200);
    tbl[14] = mk(1, 7, 32'h74,   0, 0, 0,            0, 1, 1, 7, 32'h74,   1, 32'h200);
    tbl[15] = mk(1, 7, 32'h75,   0, 0, 0,            1, 1, 1, 9, 32'h99,   0, 32'h0);
    tbl[16] = mk(1, 7, 32'h75,   0, 0, 0,            0, 1, 1, 7, 32'h75,   0, 32'h0);
    tbl[17] = mk(0, 0, 0,        0, 0, 0,            0, 1, 0, 7, 32'h75,   0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].wr, tbl[i].wreg, tbl[i].wdata, tbl[i].lv, tbl[i].lreg, tbl[i].ldata);
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(wb_stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_ready", i), 32'(lu_ready), 32'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_addr", i), 32'(rf_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_data", i), rf_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_pend", i), lu_pending, tbl[i].e_pend);
    end

    // Asynchronous reset with two results queued.
    @(negedge clk);
    drive(1, 5'd1, 32'h11, 1, 5'd20, 32'h2020);
    @(negedge clk);
    drive(1, 5'd2, 32'h22, 1, 5'd21, 32'h2121);
    @(posedge clk);
    #2;
    chk("prerst_cnt", 32'(fifo_count), 2);
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(rf_we), 0);
    chk("midrst_cnt", 32'(fifo_count), 0);
    chk("midrst_pend", lu_pending, 0);
    chk("midrst_ready", 32'(lu_ready), 1);
    chk("midrst_stall", 32'(wb_stall), 0);
    @(negedge clk);
    drive(0, '0, '0, 0, '0, '0);
    rst = 1'b0;
    model_reset();

    // Randomized traffic; the pipeline holds its request while stalled.
    stall_prev = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!stall_prev) begin
        wb_regwrite = ($urandom_range(0, 3) != 0);
        wb_reg = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        wb_data = $urandom;
      end
      lu_valid = ($urandom_range(0, 2) == 0);
      lu_reg = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      lu_data = $urandom;
      #1;
      req = wb_regwrite && (wb_reg != 0);
      ne = (mq.size() > 0);
      full = (mq.size() == DEPTH);
      fifo_g = ne && (m_force || !req);
      wb_g = req && !fifo_g;
      chk("rnd_stall", 32'(wb_stall), 32'(req && fifo_g));
      chk("rnd_ready", 32'(lu_ready), 32'(!full));
      chk("rnd_we", 32'(rf_we), 32'(m_we));
      chk("rnd_addr", 32'(rf_addr), 32'(m_addr));
      chk("rnd_data", rf_data, m_data);
      chk("rnd_cnt", 32'(fifo_count), 32'(mq.size()));
      chk("rnd_pend", lu_pending, model_pending());
      stall_prev = wb_stall;
      push = lu_valid && !full && (lu_reg != 0);
      @(posedge clk);
      if (fifo_g) begin
        m_we = 1; m_addr = mq[0].a; m_data = mq[0].d;
        void'(mq.pop_front());
      end else if (wb_g) begin
        m_we = 1; m_addr = wb_reg; m_data = wb_data;
      end else begin
        m_we = 0;
      end
      if (!ne || fifo_g) begin
        m_wait = 0; m_force = 0;
      end else if (m_wait == MW - 1) begin
        m_wait = 0; m_force = 1;
      end else begin
        m_wait++; m_force = 0;
      end
      if (push) begin
        e.a = lu_reg; e.d = lu_data;
        mq.push_back(e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
